garegga_snd_cmd_tx: RTL and testbench

Main-CPU-side sound command transmitter: the 68k end of the sound-latch protocol whose Z80 end consumes `SOUNDLATCH`, `Z80INT` and produces the latch acknowledge. It buffers 68k command writes in a small FIFO and presents one byte at a time on `SOUNDLATCH`. For each byte it raises a `Z80INT` pulse, then holds `BUSY` until the Z80 acknowledges by writing 0xE00C. It sits in the main board's CLK96 domain between the 68k address decoder and the sound board.

---
 rtl/garegga_snd_cmd_tx.sv | 189 ++++++++++++++++++
 tb/tb_garegga_snd_cmd_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/garegga_snd_cmd_tx.sv
// garegga_snd_cmd_tx: 68k-side sound command transmitter.
// Queues 68k command bytes in a small FIFO and hands them one at a time to
// the Z80: each byte is presented on SOUNDLATCH with an INT_HOLD-cycle
// Z80INT pulse, and BUSY stays high until the Z80 acknowledges (0xE00C write).
//
// Handshake: a command is "in flight" from the pop cycle's next edge until
// the Z80_ACK pulse is seen (during PULSE it is remembered, in WAIT_ACK it
// ends the command on the next edge); Z80_ACK in IDLE has no effect.
//
// Optional feature macro: GAREGGA_SND_CMD_TIMEOUT_EN -- when defined, a
// 16-bit counter abandons a byte whose ack has not arrived within TIMEOUT
// cycles of entering WAIT_ACK and sets the sticky TIMED_OUT flag.
module garegga_snd_cmd_tx #(
  parameter int          DEPTH_LOG2 = 2,
  parameter int          INT_HOLD   = 8,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic       CLK96,
  input  logic       RESET96,
  input  logic       M68K_WR,
  input  logic [7:0] M68K_DIN,
  input  logic       FLAG_CLR,
  input  logic       Z80_ACK,
  output logic [7:0] SOUNDLATCH,
  output logic       Z80INT,
  output logic       BUSY,
  output logic       FIFO_FULL,
  output logic       FIFO_EMPTY,
  output logic       OVERFLOW,
  output logic       TIMED_OUT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HW    = $clog2(INT_HOLD + 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(INT_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  push_ok, push_drop, pop;
  logic [HW-1:0]         hold_cnt;
  logic                  hold_done;
  logic                  ack_seen;

  // Full is judged on the current count, so a write while full is dropped
  // even if a pop happens in the same cycle.
  assign push_ok   = M68K_WR && (count != DEPTH_C);
  assign push_drop = M68K_WR && (count == DEPTH_C);
  assign hold_done = (hold_cnt == HOLD_LAST);

  // Z80INT and BUSY decode straight from the state register so an async
  // reset drops them immediately.
  assign Z80INT = (state == S_PULSE);
  assign BUSY   = (state != S_IDLE);

`ifdef GAREGGA_SND_CMD_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        timeout_hit;
`endif

  // Next-state logic: pop in IDLE, time the pulse, wait for the ack.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
`ifdef GAREGGA_SND_CMD_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (hold_done) begin
          state_nxt = (ack_seen || Z80_ACK) ? S_IDLE : S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (Z80_ACK) begin
          state_nxt = S_IDLE;
        end
`ifdef GAREGGA_SND_CMD_TIMEOUT_EN
        else if (to_cnt == TIMEOUT - 16'd1) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // State register.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge CLK96) begin
    if (push_ok) mem[wr_ptr] <= M68K_DIN;
  end

  // FIFO pointers, count and registered full/empty flags.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      FIFO_FULL  <= 1'b0;
      FIFO_EMPTY <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      FIFO_FULL  <= (count_nxt == DEPTH_C);
      FIFO_EMPTY <= (count_nxt == '0);
    end
  end

  // Latch the popped byte; it stays put until the next pop.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)  SOUNDLATCH <= 8'h00;
    else if (pop) SOUNDLATCH <= mem[rd_ptr];
  end

  // Pulse-width counter and early-ack memory, both restarted on each pop.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      hold_cnt <= '0;
      ack_seen <= 1'b0;
    end else if (pop) begin
      hold_cnt <= '0;
      ack_seen <= 1'b0;
    end else if (state == S_PULSE) begin
      if (!hold_done) hold_cnt <= hold_cnt + 1'b1;
      if (Z80_ACK)    ack_seen <= 1'b1;
    end
  end

  // Sticky overflow: a new drop in the same cycle as FLAG_CLR wins.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)        OVERFLOW <= 1'b0;
    else if (push_drop) OVERFLOW <= 1'b1;
    else if (FLAG_CLR)  OVERFLOW <= 1'b0;
  end

`ifdef GAREGGA_SND_CMD_TIMEOUT_EN
  // Ack timeout counter: zero on WAIT_ACK entry, counts while waiting.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)                 to_cnt <= 16'd0;
    else if (state == S_WAIT_ACK) to_cnt <= to_cnt + 16'd1;
    else                         to_cnt <= 16'd0;
  end

  // Sticky timeout flag: a new timeout in the same cycle as FLAG_CLR wins.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)          TIMED_OUT <= 1'b0;
    else if (timeout_hit) TIMED_OUT <= 1'b1;
    else if (FLAG_CLR)    TIMED_OUT <= 1'b0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign TIMED_OUT      = 1'b0;
`endif

endmodule

// File: tb/tb_garegga_snd_cmd_tx.sv
// Directed bench for garegga_snd_cmd_tx (DEPTH_LOG2=2, INT_HOLD=8, TIMEOUT=100).
// "Cycle c" is the interval after the c-th rising edge counted from the
// start of a test; inputs driven at cycle c are sampled on edge c+1.
module tb_garegga_snd_cmd_tx;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] din;
  logic       flag_clr;
  logic       ack;
  logic [7:0] soundlatch;
  logic       z80int;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       timed_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  garegga_snd_cmd_tx #(
    .DEPTH_LOG2 (2),
    .INT_HOLD   (8),
    .TIMEOUT    (16'd100)
  ) dut (
    .CLK96      (clk),
    .RESET96    (rst),
    .M68K_WR    (wr),
    .M68K_DIN   (din),
    .FLAG_CLR   (flag_clr),
    .Z80_ACK    (ack),
    .SOUNDLATCH (soundlatch),
    .Z80INT     (z80int),
    .BUSY       (busy),
    .FIFO_FULL  (fifo_full),
    .FIFO_EMPTY (fifo_empty),
    .OVERFLOW   (overflow),
    .TIMED_OUT  (timed_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic write_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    tick();
    wr  = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_int(input logic level, input string tag);
    int k;
    k = 0;
    while (z80int !== level && k < 100) begin
      tick();
      k++;
    end
    chk(tag, z80int, level);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic int_seen;
    rst = 1'b1; wr = 1'b0; din = 8'h00; flag_clr = 1'b0; ack = 1'b0;
    #2;
    // Reset values while held in reset
    chk("rst_latch", soundlatch, 8'h00);
    chk("rst_int", z80int, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_to", timed_out, 1'b0);
    repeat (2) tick();
    rst = 1'b0;

    // Idle after release: no interrupt for 1000 cycles
    int_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (z80int !== 1'b0) int_seen = 1'b1;
    end
    chk("idle_no_int", int_seen, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_empty", fifo_empty, 1'b1);

    // Single command: write 0x5A at 10, ack at 30
    cyc = 0;
    goto(10);
    write_byte(8'h5A);
    chk("single_cnt1_empty", fifo_empty, 1'b0);
    chk("single_int_c11", z80int, 1'b0);
    tick();
    for (int c = 12; c <= 19; c++) begin
      chk("single_latch", soundlatch, 8'h5A);
      chk("single_int_hi", z80int, 1'b1);
      chk("single_busy_pulse", busy, 1'b1);
      tick();
    end
    chk("single_int_lo_c20", z80int, 1'b0);
    chk("single_busy_c20", busy, 1'b1);
    goto(30);
    chk("single_busy_c30", busy, 1'b1);
    pulse_ack();
    chk("single_busy_c31", busy, 1'b0);
    chk("single_latch_kept", soundlatch, 8'h5A);

    // Burst 0x01..0x05 then 0x06 while full
    repeat (3) tick();
    exp_q = {};
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("burst_full", fifo_full, 1'b1);
    chk("burst_no_ovf", overflow, 1'b0);
    write_byte(8'h06);
    chk("burst_ovf", overflow, 1'b1);
    chk("burst_still_full", fifo_full, 1'b1);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      wait_int(1'b1, "burst_int_rise");
      e = exp_q.pop_front();
      chk("burst_latch_seq", soundlatch, e);
      wait_int(1'b0, "burst_int_fall");
      chk("burst_busy_wait", busy, 1'b1);
      pulse_ack();
    end
    tick();
    chk("burst_done_busy", busy, 1'b0);
    chk("burst_done_empty", fifo_empty, 1'b1);
    chk("burst_done_latch", soundlatch, 8'h05);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("burst_flag_clr", overflow, 1'b0);

    // Ack during PULSE: write at 10, ack at 14
    cyc = 0;
    goto(10);
    write_byte(8'hC3);
    goto(14);
    chk("early_int_c14", z80int, 1'b1);
    pulse_ack();
    goto(19);
    chk("early_int_c19", z80int, 1'b1);
    chk("early_latch", soundlatch, 8'hC3);
    tick();
    chk("early_int_c20", z80int, 1'b0);
    chk("early_busy_c20", busy, 1'b0);
    tick();
    chk("early_busy_c21", busy, 1'b0);

    // Ack never arrives
    cyc = 0;
    goto(10);
    write_byte(8'h77);
    write_byte(8'h88);
`ifdef GAREGGA_SND_CMD_TIMEOUT_EN
    // WAIT_ACK entered at cycle 20; timeout lands at 120
    goto(119);
    chk("to_not_yet", timed_out, 1'b0);
    chk("to_busy_119", busy, 1'b1);
    tick();
    chk("to_set", timed_out, 1'b1);
    chk("to_busy_120", busy, 1'b0);
    tick();
    chk("to_next_latch", soundlatch, 8'h88);
    chk("to_next_int", z80int, 1'b1);
    wait_int(1'b0, "to_next_fall");
    pulse_ack();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("to_flag_clr", timed_out, 1'b0);
`else
    goto(400);
    chk("noto_busy", busy, 1'b1);
    chk("noto_flag", timed_out, 1'b0);
    chk("noto_latch", soundlatch, 8'h77);
`endif

    // Reset mid-PULSE with two bytes queued
    do_reset();
    cyc = 0;
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    goto(4);
    chk("mid_int_before", z80int, 1'b1);
    chk("mid_latch_before", soundlatch, 8'hA1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_int", z80int, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_latch", soundlatch, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rel_empty", fifo_empty, 1'b1);
    chk("mid_rel_full", fifo_full, 1'b0);
    int_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (z80int !== 1'b0) int_seen = 1'b1;
    end
    chk("mid_rel_no_int", int_seen, 1'b0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
